mem_link_controller: RTL and testbench
======================================

# mem_link_controller

Byte-stream memory controller between the UART receiver/transmitter pair and an on-chip byte RAM. Decodes WRITE, READ and FILL commands arriving one byte at a time, and performs burst writes, burst reads and block fills with address wrap-around. Returns read data, ACK or NAK bytes through the transmitter handshake, and aborts stalled commands after a programmable idle timeout. Parametrised successor of the fixed-size controller: adds configurable depth, FILL, acknowledgements, error reporting and timeout.

## Interface
- ADDR_WIDTH, 8: internal RAM address width, 1..16.
- DEPTH, 2**ADDR_WIDTH: RAM size in bytes.
- TIMEOUT, 50000: clock cycles without `received` before an open command aborts; 0 disables the timeout.

- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- received  in  1  one-cycle strobe: `rx_byte` valid
- rx_byte  in  8  received byte
- is_transmitting  in  1  transmitter busy
- transmit  out  1  one-cycle strobe: send `tx_byte`
- tx_byte  out  8  byte to send, held stable until next strobe
- busy  out  1  high from first command byte until the response completes

## Operation
- Command frame: CMD, L, ADDR_HI, ADDR_LO, then payload. The burst count is L+1, range 1..256. The wire address is 16 bits big-endian; the internal address is that value mod DEPTH.
- WRITE (0x01): payload is L+1 data bytes. Each byte is written at addr, addr+1, … with wrap-around modulo DEPTH. After the last byte, send ACK 0x06.
- READ (0x02): no payload. Send L+1 bytes from consecutive addresses with wrap-around. No ACK follows.
- FILL (0x03): payload is one value byte V. Write V to L+1 consecutive addresses at one write per cycle, then send ACK.
- Any other CMD byte in IDLE: send NAK 0x15 and return to IDLE.
- States: IDLE, LEN, ADDR_HI, ADDR_LO, WR_DATA, FILL_VAL, FILL_RUN, RD_FETCH, TX_SEND, TX_WAIT.
  - TX_SEND/TX_WAIT serve both read data and ACK/NAK responses.
  - A `resp_is_data` flag selects where to return after each transmitted byte.
- `received` in RD_FETCH, FILL_RUN, TX_SEND or TX_WAIT is ignored and the byte is dropped.
- Timeout: in LEN, ADDR_HI, ADDR_LO, WR_DATA or FILL_VAL, an idle counter counts cycles since the last `received`. When it reaches TIMEOUT:
  - send NAK, then go to IDLE;
  - bytes already written stay written.
- Reset: state IDLE, transmit 0, tx_byte 0x00, busy 0, counters 0. RAM contents are not reset. Reset mid-burst abandons the command with no response.

## Timing
- WRITE: the RAM write occurs on the edge after the cycle in which `received` is high.
- FILL: first write one cycle after V is received. L+1 consecutive write cycles, then TX_SEND.
- READ: the RAM has 1-cycle registered read latency. RD_FETCH takes 1 cycle per byte, then TX_SEND.
- TX_SEND: when is_transmitting is 0, drive tx_byte and pulse transmit for exactly one cycle, then enter TX_WAIT.
- TX_WAIT: one mandatory guard cycle, then wait for is_transmitting to be 0. Then either fetch the next read byte or go to IDLE.
  - Consequence: transmit pulses are at least 2 cycles apart.
  - A new pulse is never issued while is_transmitting is high.
- busy falls in the cycle IDLE is re-entered.
- Back-to-back commands: a CMD byte received in the first IDLE cycle is accepted.

## Structure
- Package mem_link_pkg:
  - command codes CMD_WRITE, CMD_READ, CMD_FILL;
  - response bytes RESP_ACK, RESP_NAK;
  - state encoding.
- Sub-module mem_link_ram: single-port synchronous byte RAM, parameters ADDR_WIDTH and DEPTH, 1-cycle read latency, write-first not required.
- Remaining logic is one FSM plus an address counter, a burst counter and an idle counter.

## Test plan
- WRITE 01,02,0E,CD,42,43,44 with ADDR_WIDTH=16 → ACK 06, then READ 02,02,0E,CD → tx bytes 42,43,44 in order, pulses ≥2 cycles apart.
- Wrap-around: ADDR_WIDTH=8, WRITE L=3 at 0x00FE with data 11,22,33,44 → READ L=3 at 0x00FE returns 11,22,33,44; READ L=1 at 0x0000 returns 33,44.
- FILL 03,FF,00,00,A5 with ADDR_WIDTH=8 → 256 write cycles then ACK; READ of 0x0080 returns A5.
- Unknown CMD 0x7F → single NAK 15, busy returns low, next valid WRITE succeeds.
- TIMEOUT=20: send 01,01,00,10,AA then idle → NAK after 20 cycles; READ L=0 at 0x0010 returns AA. Hold is_transmitting high 30 cycles during a READ reply → no transmit pulse until it falls.
- Assert reset_n low mid-WRITE payload → outputs return to reset values immediately, no response sent; next command is decoded normally.

Source files
------------

// File: rtl/mem_link_pkg.sv
// Shared constants and state encoding for the byte-stream memory link controller.
package mem_link_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_FILL  = 8'h03;

  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WR_DATA,
    S_FILL_VAL,
    S_FILL_RUN,
    S_RD_FETCH,
    S_TX_SEND,
    S_TX_WAIT
  } state_t;

endpackage

// File: rtl/mem_link_ram.sv
// Single-port synchronous byte RAM with one cycle of registered read latency.
module mem_link_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_link_controller.sv
// Decodes WRITE/READ/FILL byte commands from the UART receiver, drives the byte RAM,
// and returns read data or ACK/NAK bytes through the transmitter handshake.
module mem_link_controller
  import mem_link_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 2**ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       busy,
  output state_t     state
);

  // Handshake: `received` is a one-cycle strobe qualifying rx_byte; `transmit` is a
  // one-cycle strobe issued only while is_transmitting is low, and tx_byte holds until the next one.

  logic [7:0]            cmd;
  logic [7:0]            len;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            cnt;
  logic [7:0]            fill_val;
  logic [7:0]            resp_byte;
  logic                  resp_is_data;
  logic                  guard;
  logic [31:0]           idle_cnt;

  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       in_cmd_phase;
  logic       timeout_hit;

  function automatic logic [ADDR_WIDTH-1:0] wire_to_addr(input logic [15:0] w);
    logic [31:0] m;
    m = {16'd0, w} % DEPTH;
    return m[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(DEPTH - 1)) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  assign in_cmd_phase = (state == S_LEN) || (state == S_ADDR_HI) || (state == S_ADDR_LO) ||
                        (state == S_WR_DATA) || (state == S_FILL_VAL);
  assign timeout_hit  = (TIMEOUT != 0) && (idle_cnt == TIMEOUT - 32'd1);

  // Write data is taken straight off the receive strobe so the write lands on the next edge.
  assign ram_we    = ((state == S_WR_DATA) && received) || (state == S_FILL_RUN);
  assign ram_wdata = (state == S_FILL_RUN) ? fill_val : rx_byte;

  mem_link_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      transmit     <= 1'b0;
      tx_byte      <= 8'h00;
      busy         <= 1'b0;
      cmd          <= 8'h00;
      len          <= 8'h00;
      addr_hi      <= 8'h00;
      addr         <= '0;
      cnt          <= 9'd0;
      fill_val     <= 8'h00;
      resp_byte    <= 8'h00;
      resp_is_data <= 1'b0;
      guard        <= 1'b0;
      idle_cnt     <= 32'd0;
    end else begin
      transmit <= 1'b0;
      if (in_cmd_phase && !received) idle_cnt <= idle_cnt + 32'd1;
      else                           idle_cnt <= 32'd0;

      case (state)
        S_IDLE: begin
          if (received) begin
            busy <= 1'b1;
            if (rx_byte inside {CMD_WRITE, CMD_READ, CMD_FILL}) begin
              cmd   <= rx_byte;
              state <= S_LEN;
            end else begin
              resp_is_data <= 1'b0;
              resp_byte    <= RESP_NAK;
              state        <= S_TX_SEND;
            end
          end
        end
        S_LEN, S_ADDR_HI, S_ADDR_LO, S_WR_DATA, S_FILL_VAL: begin
          if (received) begin
            case (state)
              S_LEN: begin
                len   <= rx_byte;
                state <= S_ADDR_HI;
              end
              S_ADDR_HI: begin
                addr_hi <= rx_byte;
                state   <= S_ADDR_LO;
              end
              S_ADDR_LO: begin
                addr <= wire_to_addr({addr_hi, rx_byte});
                cnt  <= {1'b0, len} + 9'd1;
                if (cmd == CMD_WRITE)     state <= S_WR_DATA;
                else if (cmd == CMD_READ) begin
                  resp_is_data <= 1'b1;
                  state        <= S_RD_FETCH;
                end else                  state <= S_FILL_VAL;
              end
              S_WR_DATA: begin
                addr <= next_addr(addr);
                cnt  <= cnt - 9'd1;
                if (cnt == 9'd1) begin
                  resp_is_data <= 1'b0;
                  resp_byte    <= RESP_ACK;
                  state        <= S_TX_SEND;
                end
              end
              default: begin
                fill_val <= rx_byte;
                state    <= S_FILL_RUN;
              end
            endcase
          end else if (timeout_hit) begin
            // Abandon the stalled command; anything already written stays in RAM.
            resp_is_data <= 1'b0;
            resp_byte    <= RESP_NAK;
            state        <= S_TX_SEND;
          end
        end
        S_FILL_RUN: begin
          addr <= next_addr(addr);
          cnt  <= cnt - 9'd1;
          if (cnt == 9'd1) begin
            resp_is_data <= 1'b0;
            resp_byte    <= RESP_ACK;
            state        <= S_TX_SEND;
          end
        end
        S_RD_FETCH: state <= S_TX_SEND;
        S_TX_SEND: begin
          if (!is_transmitting) begin
            transmit <= 1'b1;
            tx_byte  <= resp_is_data ? ram_rdata : resp_byte;
            guard    <= 1'b1;
            state    <= S_TX_WAIT;
            // The address only advances once its byte has been captured into tx_byte.
            if (resp_is_data) begin
              addr <= next_addr(addr);
              cnt  <= cnt - 9'd1;
            end
          end
        end
        S_TX_WAIT: begin
          if (guard) guard <= 1'b0;
          else if (!is_transmitting) begin
            if (resp_is_data && cnt != 9'd0) state <= S_RD_FETCH;
            else begin
              resp_is_data <= 1'b0;
              busy         <= 1'b0;
              state        <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_link_controller.sv
// Directed bench: two controller instances (8-bit address with short timeout, 16-bit address),
// a simple transmitter model, and an expected-byte queue checked against captured tx bytes.
module tb_mem_link_controller;
  import mem_link_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       received [2];
  logic [7:0] rx_byte  [2];
  logic       is_tx    [2];
  logic       transmit [2];
  logic [7:0] tx_byte  [2];
  logic       busy     [2];
  state_t     state_dbg[2];

  logic       hold     [2];
  int         tx_left  [2];
  int         last_pulse[2];
  int         cyc;
  int         pulse_cyc;
  int         fill_cyc;
  int         rd_idx;
  int         n_checks;
  int         n_errors;

  logic [7:0] rx_q [$];
  logic [7:0] exp_q[$];
  logic [7:0] cmd_q[$];

  mem_link_controller #(.ADDR_WIDTH(8), .TIMEOUT(20)) dut_a (
    .clock(clock), .reset_n(reset_n), .received(received[0]), .rx_byte(rx_byte[0]),
    .is_transmitting(is_tx[0]), .transmit(transmit[0]), .tx_byte(tx_byte[0]),
    .busy(busy[0]), .state(state_dbg[0])
  );

  mem_link_controller #(.ADDR_WIDTH(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .received(received[1]), .rx_byte(rx_byte[1]),
    .is_transmitting(is_tx[1]), .transmit(transmit[1]), .tx_byte(tx_byte[1]),
    .busy(busy[1]), .state(state_dbg[1])
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model and tx capture, sampled on the falling edge
  always @(negedge clock) begin
    cyc++;
    if (state_dbg[0] == S_FILL_RUN) fill_cyc++;
    for (int i = 0; i < 2; i++) begin
      if (transmit[i]) begin
        check("tx_gap", (cyc - last_pulse[i] >= 2) ? 1 : 0, 1);
        check("tx_while_busy", is_tx[i], 0);
        last_pulse[i] = cyc;
        pulse_cyc     = cyc;
        rx_q.push_back(tx_byte[i]);
        tx_left[i] = 4;
      end else if (tx_left[i] > 0) begin
        tx_left[i]--;
      end
      is_tx[i] = hold[i] || (tx_left[i] != 0);
    end
  end

  // Driver tasks
  task automatic send_byte(input int d, input logic [7:0] b);
    @(negedge clock);
    rx_byte[d]  = b;
    received[d] = 1'b1;
    @(negedge clock);
    received[d] = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_all(input int d);
    while (cmd_q.size() > 0) send_byte(d, cmd_q.pop_front());
  endtask

  task automatic drain(input string tag, input int limit);
    logic [15:0] got;
    for (int k = 0; k < limit && (rx_q.size() - rd_idx) < exp_q.size(); k++) @(negedge clock);
    while (exp_q.size() > 0) begin
      if (rd_idx < rx_q.size()) begin
        got = {8'h00, rx_q[rd_idx]};
        rd_idx++;
      end else begin
        got = 16'hDEAD;
      end
      check(tag, got, {8'h00, exp_q.pop_front()});
    end
  endtask

  task automatic wait_idle(input int d);
    for (int k = 0; k < 200 && busy[d]; k++) @(negedge clock);
    check("busy_low", busy[d], 0);
  endtask

  task automatic no_extra(input string tag);
    repeat (10) @(negedge clock);
    check(tag, rx_q.size() - rd_idx, 0);
  endtask

  int t0;
  int f0;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; pulse_cyc = 0; fill_cyc = 0; rd_idx = 0;
    for (int i = 0; i < 2; i++) begin
      received[i] = 1'b0; rx_byte[i] = 8'h00; is_tx[i] = 1'b0; hold[i] = 1'b0;
      tx_left[i] = 0; last_pulse[i] = -100;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("rst_transmit", transmit[i], 0);
      check("rst_tx_byte", tx_byte[i], 8'h00);
      check("rst_busy", busy[i], 0);
      check("rst_state", state_dbg[i], S_IDLE);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Burst write then read back, 16-bit address space
    send_byte(1, 8'h01);
    check("busy_after_cmd", busy[1], 1);
    cmd_q = {8'h02, 8'h0E, 8'hCD, 8'h42, 8'h43, 8'h44};
    send_all(1);
    exp_q = {8'h06};
    drain("write_ack", 100);
    wait_idle(1);
    cmd_q = {8'h02, 8'h02, 8'h0E, 8'hCD};
    send_all(1);
    exp_q = {8'h42, 8'h43, 8'h44};
    drain("read16", 200);
    wait_idle(1);

    // Wrap-around at the top of a 256-byte RAM
    cmd_q = {8'h01, 8'h03, 8'h00, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h44};
    send_all(0);
    exp_q = {8'h06};
    drain("wrap_ack", 100);
    wait_idle(0);
    cmd_q = {8'h02, 8'h03, 8'h00, 8'hFE};
    send_all(0);
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
    drain("wrap_read", 200);
    wait_idle(0);
    cmd_q = {8'h02, 8'h01, 8'h00, 8'h00};
    send_all(0);
    exp_q = {8'h33, 8'h44};
    drain("wrap_read0", 200);
    wait_idle(0);

    // Full-RAM fill
    f0 = fill_cyc;
    cmd_q = {8'h03, 8'hFF, 8'h00, 8'h00, 8'hA5};
    send_all(0);
    exp_q = {8'h06};
    drain("fill_ack", 600);
    check("fill_cycles", fill_cyc - f0, 256);
    wait_idle(0);
    cmd_q = {8'h02, 8'h00, 8'h00, 8'h80};
    send_all(0);
    exp_q = {8'hA5};
    drain("fill_read", 100);
    wait_idle(0);

    // Unknown command gets exactly one NAK
    send_byte(0, 8'h7F);
    exp_q = {8'h15};
    drain("nak", 100);
    wait_idle(0);
    no_extra("nak_single");
    cmd_q = {8'h01, 8'h00, 8'h00, 8'h40, 8'h5A};
    send_all(0);
    exp_q = {8'h06};
    drain("after_nak_ack", 100);
    wait_idle(0);
    cmd_q = {8'h02, 8'h00, 8'h00, 8'h40};
    send_all(0);
    exp_q = {8'h5A};
    drain("after_nak_read", 100);
    wait_idle(0);

    // Stalled WRITE times out after 20 idle cycles
    cmd_q = {8'h01, 8'h01, 8'h00, 8'h10, 8'hAA};
    send_all(0);
    t0 = cyc;
    exp_q = {8'h15};
    drain("timeout_nak", 60);
    check("timeout_lat", (pulse_cyc - t0 >= 18 && pulse_cyc - t0 <= 25) ? 1 : 0, 1);
    wait_idle(0);

    // Reply held off while the transmitter stays busy
    hold[0] = 1'b1;
    cmd_q = {8'h02, 8'h00, 8'h00, 8'h10};
    send_all(0);
    repeat (30) @(negedge clock);
    check("held_silent", rx_q.size() - rd_idx, 0);
    hold[0] = 1'b0;
    exp_q = {8'hAA};
    drain("timeout_kept", 100);
    wait_idle(0);

    // Reset in the middle of a write payload
    cmd_q = {8'h01, 8'h03, 8'h00, 8'h20, 8'h01, 8'h02};
    send_all(0);
    check("busy_mid_write", busy[0], 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_transmit", transmit[0], 0);
    check("mid_rst_tx_byte", tx_byte[0], 8'h00);
    check("mid_rst_state", state_dbg[0], S_IDLE);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    no_extra("rst_no_resp");
    cmd_q = {8'h02, 8'h01, 8'h00, 8'h20};
    send_all(0);
    exp_q = {8'h01, 8'h02};
    drain("after_rst_read", 200);
    wait_idle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
